// File: rtl/pp_pkg.sv
// Shared ping-pong buffering definitions for the input and output controllers.
package pp_pkg;

  localparam int BLOCK_SIZE = 2;

  typedef logic [1:0] pp_state_t;

  localparam pp_state_t S_IDLE = 2'd0;
  localparam pp_state_t S_RUN  = 2'd1;
  localparam pp_state_t S_DONE = 2'd2;

endpackage

// File: rtl/pp_out_bank.sv
// One output row of result blocks: synchronous write port, combinational read port.
// Contents are deliberately left unreset; validity is tracked by the controller.
module pp_out_bank
  import pp_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pp_out_drain_ctrl.sv
// Ping-pong output buffer: fills one bank of COL_Y result blocks while draining the other
// on a valid/ready stream; a full row is visible one cycle after its last write.
module pp_out_drain_ctrl
  import pp_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int COL_Y    = 4,
  parameter int MAX_ROWS = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_W-1:0]               out_data,
  output logic                            out_last,
  output logic [$clog2(MAX_ROWS+1)-1:0]   out_row_idx,
  output logic                            wr_bank,
  output logic                            done
);

  localparam int AW = $clog2(COL_Y);
  localparam int RW = $clog2(MAX_ROWS + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(COL_Y - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(MAX_ROWS - 1);
  localparam logic [RW-1:0] ROW_SAT   = RW'(MAX_ROWS);

  pp_state_t        r_state;
  logic             r_wr_sel;
  logic             r_rd_sel;
  logic [AW-1:0]    r_wr_addr;
  logic [AW-1:0]    r_rd_addr;
  logic [1:0]       r_bank_full;
  logic [RW-1:0]    r_rows_drained;

  logic             w_run;
  logic             w_wr_fire;
  logic             w_rd_fire;
  logic             w_wr_last;
  logic             w_rd_last;
  logic [1:0]       w_bank_full_nxt;
  logic [DATA_W-1:0] w_rdata [2];

  // Handshake qualifiers depend only on registered state, never on in_valid/out_ready.
  assign w_run     = (r_state == S_RUN);
  assign in_ready  = w_run & ~r_bank_full[r_wr_sel];
  assign out_valid = w_run &  r_bank_full[r_rd_sel];
  assign w_wr_fire = in_valid & in_ready;
  assign w_rd_fire = out_valid & out_ready;
  assign w_wr_last = w_wr_fire & (r_wr_addr == LAST_ADDR);
  assign w_rd_last = w_rd_fire & (r_rd_addr == LAST_ADDR);

  // Writer and reader always point at different banks when both complete a row.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_wr_last) w_bank_full_nxt[r_wr_sel] = 1'b1;
    if (w_rd_last) w_bank_full_nxt[r_rd_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_wr_sel       <= 1'b0;
      r_rd_sel       <= 1'b0;
      r_wr_addr      <= '0;
      r_rd_addr      <= '0;
      r_bank_full    <= 2'b00;
      r_rows_drained <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_RUN;
        S_RUN:   if (w_rd_last && (r_rows_drained == LAST_ROW)) r_state <= S_DONE;
        default: r_state <= r_state;
      endcase

      if (w_wr_fire) begin
        if (r_wr_addr == LAST_ADDR) begin
          r_wr_addr <= '0;
          r_wr_sel  <= ~r_wr_sel;
        end else begin
          r_wr_addr <= r_wr_addr + AW'(1);
        end
      end

      if (w_rd_fire) begin
        if (r_rd_addr == LAST_ADDR) begin
          r_rd_addr <= '0;
          r_rd_sel  <= ~r_rd_sel;
          if (r_rows_drained != ROW_SAT) r_rows_drained <= r_rows_drained + RW'(1);
        end else begin
          r_rd_addr <= r_rd_addr + AW'(1);
        end
      end

      r_bank_full <= w_bank_full_nxt;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pp_out_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (COL_Y)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_wr_fire && (r_wr_sel == 1'(b))),
      .i_waddr (r_wr_addr),
      .i_wdata (in_data),
      .i_raddr (r_rd_addr),
      .o_rdata (w_rdata[b])
    );
  end

  assign out_data    = w_rdata[r_rd_sel];
  assign out_last    = out_valid & (r_rd_addr == LAST_ADDR);
  assign out_row_idx = r_rows_drained;
  assign wr_bank     = r_wr_sel;
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_pp_out_drain_ctrl.sv
// Two instances (MAX_ROWS=16 and MAX_ROWS=2) share stimulus and are compared each cycle
// against a row-queue reference model.
module tb_pp_out_drain_ctrl;

  localparam int DW  = 64;
  localparam int CY  = 4;
  localparam int MR0 = 16;
  localparam int MR1 = 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          ir0, ov0, ol0, wb0, dn0;
  logic [DW-1:0] od0;
  logic [4:0]    ri0;
  logic          ir1, ov1, ol1, wb1, dn1;
  logic [DW-1:0] od1;
  logic [1:0]    ri1;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: one ordered block store per instance plus row bookkeeping.
  logic [63:0] m_buf [2][256];
  int m_state [2];
  int m_head [2];
  int m_tail [2];
  int m_wcnt [2];
  int m_wrows [2];
  int m_full [2];
  int m_ridx [2];
  int m_drained [2];
  int m_max [2];

  always #5 clk = ~clk;

  pp_out_drain_ctrl #(.DATA_W(DW), .COL_Y(CY), .MAX_ROWS(MR0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_last(ol0),
    .out_row_idx(ri0), .wr_bank(wb0), .done(dn0)
  );

  pp_out_drain_ctrl #(.DATA_W(DW), .COL_Y(CY), .MAX_ROWS(MR1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1),
    .out_row_idx(ri1), .wr_bank(wb1), .done(dn1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_state[m] = M_IDLE; m_head[m] = 0; m_tail[m] = 0; m_wcnt[m] = 0;
      m_wrows[m] = 0; m_full[m] = 0; m_ridx[m] = 0; m_drained[m] = 0;
    end
  endtask

  function automatic logic exp_ready(input int m);
    return (m_state[m] == M_RUN) && (m_full[m] < 2);
  endfunction

  function automatic logic exp_valid(input int m);
    return (m_state[m] == M_RUN) && (m_full[m] > 0);
  endfunction

  task automatic model_update(input logic rn, input logic st, input logic iv,
                              input logic [63:0] d, input logic ordy);
    logic ir, ov;
    if (!rn) begin
      model_reset();
    end else begin
      for (int m = 0; m < 2; m++) begin
        ir = exp_ready(m);
        ov = exp_valid(m);
        if (ov && ordy) begin
          m_head[m]++;
          m_ridx[m]++;
          if (m_ridx[m] == CY) begin
            m_ridx[m] = 0;
            m_full[m]--;
            if (m_drained[m] < m_max[m]) m_drained[m]++;
            if (m_drained[m] == m_max[m]) m_state[m] = M_DONE;
          end
        end
        if (ir && iv) begin
          m_buf[m][m_tail[m] % 256] = d;
          m_tail[m]++;
          m_wcnt[m]++;
          if (m_wcnt[m] == CY) begin
            m_wcnt[m] = 0;
            m_full[m]++;
            m_wrows[m]++;
          end
        end
        if (m_state[m] == M_IDLE && st) m_state[m] = M_RUN;
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] g_ir, g_ov, g_od, g_ol, g_ri, g_wb, g_dn;
    logic ev;
    for (int m = 0; m < 2; m++) begin
      if (m == 0) begin
        g_ir = 64'(ir0); g_ov = 64'(ov0); g_od = od0; g_ol = 64'(ol0);
        g_ri = 64'(ri0); g_wb = 64'(wb0); g_dn = 64'(dn0);
      end else begin
        g_ir = 64'(ir1); g_ov = 64'(ov1); g_od = od1; g_ol = 64'(ol1);
        g_ri = 64'(ri1); g_wb = 64'(wb1); g_dn = 64'(dn1);
      end
      ev = exp_valid(m);
      chk($sformatf("d%0d.in_ready", m),  g_ir, 64'(exp_ready(m)));
      chk($sformatf("d%0d.out_valid", m), g_ov, 64'(ev));
      if (ev) chk($sformatf("d%0d.out_data", m), g_od, m_buf[m][m_head[m] % 256]);
      chk($sformatf("d%0d.out_last", m),  g_ol, 64'(ev && (m_ridx[m] == CY - 1)));
      chk($sformatf("d%0d.row_idx", m),   g_ri, 64'(m_drained[m]));
      chk($sformatf("d%0d.wr_bank", m),   g_wb, 64'(m_wrows[m] % 2));
      chk($sformatf("d%0d.done", m),      g_dn, 64'(m_state[m] == M_DONE));
    end
  endtask

  // Called at a falling edge: drive, check current outputs, clock, advance the model.
  task automatic step(input logic rn, input logic st, input logic iv,
                      input logic [63:0] d, input logic ordy);
    rst_n = rn; start = st; in_valid = iv; in_data = d; out_ready = ordy;
    check_all();
    @(posedge clk);
    model_update(rn, st, iv, d, ordy);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 64'd0, ordy);
  endtask

  task automatic reset_start();
    step(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
  endtask

  initial begin
    logic acc;
    logic hold;
    logic iv_r, rn_r, st_r, or_r;
    logic [63:0] d_r;

    m_max[0] = MR0;
    m_max[1] = MR1;
    model_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Back-to-back row with an always-ready sink.
    step(1'b1, 1'b1, 1'b0, 64'd0, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b1, 64'(i), 1'b1);
    idle(6, 1'b1);

    // Fill both banks against a stalled sink, then hold a ninth block until accepted.
    reset_start();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 64'h10 + 64'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 64'h18, 1'b0);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = exp_ready(0);
      step(1'b1, 1'b0, 1'b1, 64'h18, 1'b1);
    end
    chk("t2.ninth_accepted", 64'(acc), 64'd1);
    idle(12, 1'b1);

    // Short-run instance finishes after two rows and ignores further input.
    reset_start();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 64'h40 + 64'(i), 1'b1);
    idle(6, 1'b1);
    chk("t4.done", 64'(dn1), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 64'h50, 1'b1);
    chk("t4.in_ready", 64'(ir1), 64'd0);

    // Reset mid-row discards partial data; the next row drains from address 0.
    reset_start();
    step(1'b1, 1'b0, 1'b1, 64'hA1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 64'hA2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk("t5.in_ready", 64'(ir0), 64'd0);
    chk("t5.out_valid", 64'(ov0), 64'd0);
    chk("t5.wr_bank", 64'(wb0), 64'd0);
    chk("t5.done", 64'(dn0), 64'd0);
    step(1'b1, 1'b1, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 64'hB0 + 64'(i), 1'b1);
    idle(6, 1'b1);

    // Last write into bank 1 coincides with last read from bank 0.
    reset_start();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 64'h60 + 64'(i), 1'b0);
    for (int i = 4; i < 7; i++) step(1'b1, 1'b0, 1'b1, 64'h60 + 64'(i), 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b0, 1'b1, 64'h67, 1'b1);
    chk("t6.out_valid", 64'(ov0), 64'd1);
    chk("t6.wr_bank", 64'(wb0), 64'd0);
    chk("t6.in_ready", 64'(ir0), 64'd1);
    chk("t6.out_data", od0, 64'h64);
    idle(6, 1'b1);

    // Random valid/ready traffic with upstream holding data while stalled.
    reset_start();
    hold = 1'b0; iv_r = 1'b0; d_r = '0;
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        iv_r = ($urandom_range(0, 9) < 7);
        d_r  = {$urandom, $urandom};
      end
      or_r = 1'($urandom_range(0, 1));
      rn_r = ($urandom_range(0, 249) != 0);
      st_r = ($urandom_range(0, 15) == 0);
      acc  = exp_ready(0);
      step(rn_r, st_r, iv_r, d_r, or_r);
      hold = iv_r && !acc && rn_r;
    end
    idle(10, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
